// File: rtl/vc_demux_fifo_if.sv
// +----------------------------------------------------------------------------+
// | vc_demux_fifo_if : merged-stream input and per-channel FIFO read bundle    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface vc_demux_fifo_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;

  logic                  pop_vchanel0;
  logic                  pop_vchanel1;
  logic                  pop_vchanel2;
  logic                  pop_vchanel3;

  logic [DATA_WIDTH-1:0] out_vchanel0;
  logic [DATA_WIDTH-1:0] out_vchanel1;
  logic [DATA_WIDTH-1:0] out_vchanel2;
  logic [DATA_WIDTH-1:0] out_vchanel3;

  logic                  empty_vchanel0;
  logic                  empty_vchanel1;
  logic                  empty_vchanel2;
  logic                  empty_vchanel3;

  logic                  full_vchanel0;
  logic                  full_vchanel1;
  logic                  full_vchanel2;
  logic                  full_vchanel3;

  logic                  pause;
  logic                  error;
  logic [7:0]            drop_count;

  // Upstream sender and downstream consumers, seen as one agent.
  modport master (
    output in_valid, in_data,
    output pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3,
    input  out_vchanel0, out_vchanel1, out_vchanel2, out_vchanel3,
    input  empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3,
    input  full_vchanel0, full_vchanel1, full_vchanel2, full_vchanel3,
    input  pause, error, drop_count
  );

  modport slave (
    input  in_valid, in_data,
    input  pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3,
    output out_vchanel0, out_vchanel1, out_vchanel2, out_vchanel3,
    output empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3,
    output full_vchanel0, full_vchanel1, full_vchanel2, full_vchanel3,
    output pause, error, drop_count
  );
endinterface

`default_nettype wire

// File: rtl/vc_demux_fifo.sv
// +----------------------------------------------------------------------------+
// | vc_demux_fifo : steers a merged word stream into four per-channel FIFOs    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module vc_demux_fifo #(
  parameter int DATA_WIDTH = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_THRESH  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enb,
  vc_demux_fifo_if.slave bus
);

  localparam int NUM_CH = 4;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);

  logic [NUM_CH-1:0]     pop_req;
  logic [NUM_CH-1:0]     ch_empty;
  logic [NUM_CH-1:0]     ch_full;
  logic [NUM_CH-1:0]     ch_almost_full;
  logic [NUM_CH-1:0]     ch_push;
  logic [NUM_CH-1:0]     ch_pop;
  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
  logic [1:0]            dest;
  logic                  drop;
  logic                  error_flag;
  logic [7:0]            drop_cnt;

  assign pop_req = {bus.pop_vchanel3, bus.pop_vchanel2,
                    bus.pop_vchanel1, bus.pop_vchanel0};
  assign dest    = bus.in_data[DATA_WIDTH-1 -: 2];

  // Full is taken from the pre-edge count, so a same-cycle pop never frees room.
  assign drop    = enb & bus.in_valid & ch_full[dest];

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0]      wr_ptr;
      logic [PTR_W-1:0]      rd_ptr;
      logic [CNT_W-1:0]      cnt;
      logic [DATA_WIDTH-1:0] rd_data;

      assign ch_empty[i]       = (cnt == '0);
      assign ch_full[i]        = (cnt == CNT_FULL);
      assign ch_almost_full[i] = (cnt >= CNT_AF);
      assign ch_push[i]        = enb & bus.in_valid & (dest == 2'(i)) & ~ch_full[i];
      assign ch_pop[i]         = enb & pop_req[i] & ~ch_empty[i];
      assign ch_data[i]        = rd_data;

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr  <= '0;
          rd_ptr  <= '0;
          cnt     <= '0;
          rd_data <= '0;
        end else begin
          if (ch_push[i]) begin
            mem[wr_ptr] <= bus.in_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
          end
          if (ch_pop[i]) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + PTR_W'(1);
          end
          unique case ({ch_push[i], ch_pop[i]})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
          endcase
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      error_flag <= 1'b0;
      drop_cnt   <= 8'd0;
    end else if (drop) begin
      error_flag <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign bus.out_vchanel0   = ch_data[0];
  assign bus.out_vchanel1   = ch_data[1];
  assign bus.out_vchanel2   = ch_data[2];
  assign bus.out_vchanel3   = ch_data[3];

  assign bus.empty_vchanel0 = ch_empty[0];
  assign bus.empty_vchanel1 = ch_empty[1];
  assign bus.empty_vchanel2 = ch_empty[2];
  assign bus.empty_vchanel3 = ch_empty[3];

  assign bus.full_vchanel0  = ch_full[0];
  assign bus.full_vchanel1  = ch_full[1];
  assign bus.full_vchanel2  = ch_full[2];
  assign bus.full_vchanel3  = ch_full[3];

  assign bus.pause          = |ch_almost_full;
  assign bus.error          = error_flag;
  assign bus.drop_count     = drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_vc_demux_fifo.sv
// +----------------------------------------------------------------------------+
// | tb_vc_demux_fifo : directed table plus hand sequences for vc_demux_fifo    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vc_demux_fifo;

  logic clk = 1'b0;
  logic rst;
  logic enb;

  int n_checks = 0;
  int n_fail   = 0;

  vc_demux_fifo_if #(.DATA_WIDTH(6)) bus ();

  vc_demux_fifo #(
    .DATA_WIDTH(6),
    .FIFO_DEPTH(4),
    .AF_THRESH (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enb(enb),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       enb;
    logic       vld;
    logic [5:0] data;
    logic [3:0] pop;
    logic [5:0] o0;
    logic [5:0] o1;
    logic [5:0] o2;
    logic [5:0] o3;
    logic [3:0] emp;
    logic [3:0] full;
    logic       pause;
    logic       err;
    logic [7:0] dc;
  } vec_t;

  vec_t tbl [18];

  function automatic logic [3:0] emp_vec();
    return {bus.empty_vchanel3, bus.empty_vchanel2, bus.empty_vchanel1, bus.empty_vchanel0};
  endfunction

  function automatic logic [3:0] full_vec();
    return {bus.full_vchanel3, bus.full_vchanel2, bus.full_vchanel1, bus.full_vchanel0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic cyc(input logic r, input logic e, input logic v,
                     input logic [5:0] d, input logic [3:0] p);
    rst              = r;
    enb              = e;
    bus.in_valid     = v;
    bus.in_data      = d;
    bus.pop_vchanel0 = p[0];
    bus.pop_vchanel1 = p[1];
    bus.pop_vchanel2 = p[2];
    bus.pop_vchanel3 = p[3];
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] d);
    cyc(1'b0, 1'b1, 1'b1, d, 4'h0);
  endtask

  task automatic pop(input logic [3:0] p);
    cyc(1'b0, 1'b1, 1'b0, 6'h00, p);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            rst enb vld data   pop   o0     o1     o2     o3     emp   full  pa er dc
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 6'h3F, 4'h0, 6'h00, 6'h00, 6'h00, 6'h00, 4'hF, 4'h0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 6'h3F, 4'h0, 6'h00, 6'h00, 6'h00, 6'h00, 4'hF, 4'h0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 6'h05, 4'h0, 6'h00, 6'h00, 6'h00, 6'h00, 4'hE, 4'h0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 6'h1A, 4'h0, 6'h00, 6'h00, 6'h00, 6'h00, 4'hC, 4'h0, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 6'h23, 4'h0, 6'h00, 6'h00, 6'h00, 6'h00, 4'h8, 4'h0, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 6'h3F, 4'h0, 6'h00, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 6'h00, 4'hF, 6'h05, 6'h1A, 6'h23, 6'h3F, 4'hF, 4'h0, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 6'h30, 4'h0, 6'h05, 6'h1A, 6'h23, 6'h3F, 4'h7, 4'h0, 1'b0, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 6'h31, 4'h0, 6'h05, 6'h1A, 6'h23, 6'h3F, 4'h7, 4'h0, 1'b0, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 6'h32, 4'h0, 6'h05, 6'h1A, 6'h23, 6'h3F, 4'h7, 4'h0, 1'b1, 1'b0, 8'd0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 6'h33, 4'h0, 6'h05, 6'h1A, 6'h23, 6'h3F, 4'h7, 4'h8, 1'b1, 1'b0, 8'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 6'h34, 4'h0, 6'h05, 6'h1A, 6'h23, 6'h3F, 4'h7, 4'h8, 1'b1, 1'b1, 8'd1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 6'h00, 4'h8, 6'h05, 6'h1A, 6'h23, 6'h30, 4'h7, 4'h0, 1'b1, 1'b1, 8'd1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 6'h00, 4'h8, 6'h05, 6'h1A, 6'h23, 6'h31, 4'h7, 4'h0, 1'b0, 1'b1, 8'd1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 6'h00, 4'h8, 6'h05, 6'h1A, 6'h23, 6'h32, 4'h7, 4'h0, 1'b0, 1'b1, 8'd1};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 6'h00, 4'h8, 6'h05, 6'h1A, 6'h23, 6'h33, 4'hF, 4'h0, 1'b0, 1'b1, 8'd1};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 6'h00, 4'h8, 6'h05, 6'h1A, 6'h23, 6'h33, 4'hF, 4'h0, 1'b0, 1'b1, 8'd1};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 6'h00, 4'hF, 6'h05, 6'h1A, 6'h23, 6'h33, 4'hF, 4'h0, 1'b0, 1'b1, 8'd1};

    rst = 1'b1; enb = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.pop_vchanel0 = 1'b0; bus.pop_vchanel1 = 1'b0;
    bus.pop_vchanel2 = 1'b0; bus.pop_vchanel3 = 1'b0;
    #2;

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].rst, tbl[i].enb, tbl[i].vld, tbl[i].data, tbl[i].pop);
      chk($sformatf("row%0d out0", i), 32'(bus.out_vchanel0), 32'(tbl[i].o0));
      chk($sformatf("row%0d out1", i), 32'(bus.out_vchanel1), 32'(tbl[i].o1));
      chk($sformatf("row%0d out2", i), 32'(bus.out_vchanel2), 32'(tbl[i].o2));
      chk($sformatf("row%0d out3", i), 32'(bus.out_vchanel3), 32'(tbl[i].o3));
      chk($sformatf("row%0d empty", i), 32'(emp_vec()), 32'(tbl[i].emp));
      chk($sformatf("row%0d full", i), 32'(full_vec()), 32'(tbl[i].full));
      chk($sformatf("row%0d pause", i), 32'(bus.pause), 32'(tbl[i].pause));
      chk($sformatf("row%0d error", i), 32'(bus.error), 32'(tbl[i].err));
      chk($sformatf("row%0d drop_count", i), 32'(bus.drop_count), 32'(tbl[i].dc));
    end

    // Same-cycle push and pop on ch0 holding two words.
    cyc(1'b1, 1'b1, 1'b0, 6'h00, 4'h0);
    push(6'h01);
    push(6'h02);
    cyc(1'b0, 1'b1, 1'b1, 6'h03, 4'h1);
    chk("pp out0", 32'(bus.out_vchanel0), 32'h01);
    chk("pp empty0", 32'(bus.empty_vchanel0), 32'd0);
    pop(4'h1);
    chk("pp drain1", 32'(bus.out_vchanel0), 32'h02);
    pop(4'h1);
    chk("pp drain2", 32'(bus.out_vchanel0), 32'h03);
    chk("pp empty after 2", 32'(bus.empty_vchanel0), 32'd1);

    // Same-cycle push and pop on a full ch0: push dropped, count falls to 3.
    push(6'h04); push(6'h05); push(6'h06); push(6'h07);
    chk("ff full0", 32'(bus.full_vchanel0), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 6'h08, 4'h1);
    chk("ff out0", 32'(bus.out_vchanel0), 32'h04);
    chk("ff full0 after", 32'(bus.full_vchanel0), 32'd0);
    chk("ff pause", 32'(bus.pause), 32'd1);
    chk("ff drop_count", 32'(bus.drop_count), 32'd1);
    chk("ff error", 32'(bus.error), 32'd1);
    pop(4'h1); chk("ff drain1", 32'(bus.out_vchanel0), 32'h05);
    pop(4'h1); chk("ff drain2", 32'(bus.out_vchanel0), 32'h06);
    pop(4'h1); chk("ff drain3", 32'(bus.out_vchanel0), 32'h07);
    chk("ff empty0", 32'(bus.empty_vchanel0), 32'd1);
    pop(4'h1); chk("ff empty pop holds", 32'(bus.out_vchanel0), 32'h07);

    // Pointer wrap on ch2.
    for (int i = 0; i < 10; i++) begin
      push(6'(8'h20 + i));
      chk($sformatf("wrap%0d empty2 after push", i), 32'(bus.empty_vchanel2), 32'd0);
      pop(4'h4);
      chk($sformatf("wrap%0d out2", i), 32'(bus.out_vchanel2), 32'h20 + i);
      chk($sformatf("wrap%0d empty2", i), 32'(bus.empty_vchanel2), 32'd1);
    end

    // Mid-stream reset with ch1 holding two words.
    push(6'h11);
    push(6'h12);
    chk("mrst empty1 before", 32'(bus.empty_vchanel1), 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 6'h13, 4'h2);
    chk("mrst empty1", 32'(bus.empty_vchanel1), 32'd1);
    chk("mrst out1", 32'(bus.out_vchanel1), 32'd0);
    chk("mrst error", 32'(bus.error), 32'd0);
    chk("mrst drop_count", 32'(bus.drop_count), 32'd0);

    // Enable gating with a word resident in ch1.
    push(6'h15);
    cyc(1'b0, 1'b0, 1'b1, 6'h16, 4'hF);
    chk("enb empty1", 32'(bus.empty_vchanel1), 32'd0);
    chk("enb out1", 32'(bus.out_vchanel1), 32'd0);
    chk("enb empty vec", 32'(emp_vec()), 32'hD);
    pop(4'h2);
    chk("enb pop out1", 32'(bus.out_vchanel1), 32'h15);
    chk("enb pop empty1", 32'(bus.empty_vchanel1), 32'd1);

    // drop_count saturation on a full ch1.
    push(6'h10); push(6'h11); push(6'h12); push(6'h13);
    chk("sat full1", 32'(bus.full_vchanel1), 32'd1);
    for (int k = 1; k <= 300; k++) begin
      push(6'h1F);
      if (k == 254) chk("sat dc254", 32'(bus.drop_count), 32'd254);
    end
    chk("sat drop_count", 32'(bus.drop_count), 32'd255);
    chk("sat error", 32'(bus.error), 32'd1);
    chk("sat full1 kept", 32'(bus.full_vchanel1), 32'd1);
    pop(4'h2);
    chk("sat first word", 32'(bus.out_vchanel1), 32'h10);
    cyc(1'b1, 1'b0, 1'b0, 6'h00, 4'h0);
    chk("sat rst error", 32'(bus.error), 32'd0);
    chk("sat rst drop_count", 32'(bus.drop_count), 32'd0);
    chk("sat rst empty", 32'(emp_vec()), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
